// File: rtl/apb_mux_dec_pkg.sv
// Shared encodings for the AHB2APB bridge: APB mux FSM states, default bus widths
// and the access-timeout counter width used by the interface FSM and the decoder.
package apb_mux_dec_pkg;

    localparam int PADDR_W_DEF    = 16;
    localparam int APB_DATA_W_DEF = 32;
    localparam int TO_CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mux_state_t;

endpackage

// File: rtl/apb_mux_dec_if.sv
// APB request from the interface FSM plus the per-slave select/response lines.
// master = interface FSM and slave side driver, slave = apb_mux_dec.
interface apb_mux_dec_if
    import apb_mux_dec_pkg::*;
#(
    parameter int NUM_SLV        = 4,
    parameter int PADDR_WIDTH    = PADDR_W_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_W_DEF
);
    logic                              psel_en;
    logic [PADDR_WIDTH-1:0]            paddr;
    logic                              penable;
    logic                              pwrite;
    logic [NUM_SLV-1:0]                psel_x;
    logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata_in;
    logic [NUM_SLV-1:0]                pready_in;
    logic [NUM_SLV-1:0]                pslverr_in;
    logic                              pready_x;
    logic                              pslverr_x;
    logic [APB_DATA_WIDTH-1:0]         hrdata;

    modport master (
        output psel_en, paddr, penable, pwrite, prdata_in, pready_in, pslverr_in,
        input  psel_x, pready_x, pslverr_x, hrdata
    );

    modport slave (
        input  psel_en, paddr, penable, pwrite, prdata_in, pready_in, pslverr_in,
        output psel_x, pready_x, pslverr_x, hrdata
    );
endinterface

// File: rtl/apb_mux_timeout.sv
// Access watchdog: saturating cycle counter with sync clear/enable; o_tc is combinational
// from the registered count, so terminal count is seen in the same cycle the count reaches it.
module apb_mux_timeout
    import apb_mux_dec_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic hclk,
    input  logic hreset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [TO_CNT_W-1:0] r_cnt;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {TO_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + TO_CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_mux_dec.sv
// APB slave decode/mux: psel/ready/err combinational from latched index, hrdata one cycle after completion;
// psel_en drop aborts silently. Unmapped/timeout force an error. Optional err_cnt via APB_MUX_ERR_CNT_EN.
module apb_mux_dec
    import apb_mux_dec_pkg::*;
#(
    parameter int NUM_SLV        = 4,
    parameter int PADDR_WIDTH    = PADDR_W_DEF,
    parameter int APB_DATA_WIDTH = APB_DATA_W_DEF,
    parameter int IDX_LSB        = 12,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         hclk,
    input  logic         hreset_n,
    apb_mux_dec_if.slave bus
`ifdef APB_MUX_ERR_CNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);
    mux_state_t                r_state;
    logic [IDX_WIDTH-1:0]      r_idx;
    logic                      r_unmapped;
    logic [APB_DATA_WIDTH-1:0] r_hrdata;

    logic [IDX_WIDTH-1:0]      w_idx_new;
    logic                      w_unmapped_new;
    logic [NUM_SLV-1:0]        w_onehot;
    logic                      w_sel_rdy;
    logic                      w_sel_err;
    logic [APB_DATA_WIDTH-1:0] w_sel_dat;
    logic                      w_tc;
    logic                      w_done;
    logic                      w_err;
    logic                      w_rd_load;
    logic                      w_unused_addr;

    assign w_idx_new      = bus.paddr[IDX_LSB +: IDX_WIDTH];
    assign w_unmapped_new = (int'(w_idx_new) >= NUM_SLV);
    assign w_unused_addr  = &{1'b0, bus.paddr};

    // Only the latched index steers the mux; paddr is ignored once the transfer is decoded.
    always_comb begin
        w_onehot  = '0;
        w_sel_rdy = 1'b0;
        w_sel_err = 1'b0;
        w_sel_dat = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == IDX_WIDTH'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_rdy   = bus.pready_in[i];
                w_sel_err   = bus.pslverr_in[i];
                w_sel_dat   = bus.prdata_in[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    assign w_done    = (r_state == ST_ACCESS) && bus.psel_en && (r_unmapped || w_sel_rdy || w_tc);
    // A ready slave always wins over a coincident timeout.
    assign w_err     = r_unmapped || !w_sel_rdy || w_sel_err;
    assign w_rd_load = w_done && w_sel_rdy && !bus.pwrite && !w_sel_err;

    assign bus.psel_x    = (bus.psel_en && (r_state != ST_IDLE) && !r_unmapped) ? w_onehot : '0;
    assign bus.pready_x  = w_done;
    assign bus.pslverr_x = w_done && w_err;
    assign bus.hrdata    = r_hrdata;

    apb_mux_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .i_clr    ((r_state == ST_SETUP) && bus.psel_en && bus.penable),
        .i_en     ((r_state == ST_ACCESS) && !w_sel_rdy),
        .o_tc     (w_tc)
    );

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_unmapped <= 1'b0;
            r_hrdata   <= '0;
        end else begin
            if (w_rd_load) begin
                r_hrdata <= w_sel_dat;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.psel_en) begin
                        r_idx      <= w_idx_new;
                        r_unmapped <= w_unmapped_new;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!bus.psel_en) begin
                        r_state <= ST_IDLE;
                    end else if (bus.penable) begin
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.psel_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!bus.psel_en) begin
                        r_state <= ST_IDLE;
                    end else if (!bus.penable) begin
                        r_idx      <= w_idx_new;
                        r_unmapped <= w_unmapped_new;
                        r_state    <= ST_SETUP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef APB_MUX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_err_cnt <= 8'd0;
        end else if (w_done && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif
endmodule
